pipe_ctl: RTL and testbench
===========================

# pipe_ctl

Pipelined control unit for the 5-stage MIPS core. It decodes the instruction in ID into a control word and carries that word through registered EX, MEM and WB stages. It detects load-use hazards and inserts bubbles, applies flush on redirect and freeze on memory stall, and optionally tracks a multi-cycle mult/div unit. It sits between the instruction classifier (which supplies `id_flags`) and the datapath stage muxes.

## Interface

Parameters:
- `ALU_FUNC_W`, 4: width of the ALU function code.
- `MULDIV_LAT`, 4: mult/div occupancy in cycles, legal range 2..15.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_ins`  in  32  instruction in ID.
- `id_flags`  in  8  {typeR_ALU, typeR_jr, typeI_ALU, typeI_Branch, typeI_Load, typeI_Store, typeJ, typeCP0_eret}.
- `id_valid`  in  1  ID holds a real instruction.
- `mem_stall`  in  1  data memory not ready; freeze.
- `ex_redirect`  in  1  taken branch/jump resolved in EX; kill the instruction in ID.
- `id_stall`  out  1  hold PC and the IF/ID register.
- `ex_valid`, `ex_alu_b_imm`, `ex_imm_ext_sign`, `ex_overflow_aware`  out  1 each.
- `ex_alu_func`  out  ALU_FUNC_W.
- `ex_pc_ctl_func`  out  2  00 seq, 01 branch, 10 jump, 11 jr.
- `mem_valid`, `mem_we`, `mem_re`, `mem_load_sign_ext`  out  1 each.
- `mem_data_len`  out  2  taken from ins[27:26].
- `wb_valid`, `wb_gpr_we`  out  1 each.
- `wb_gpr_src`  out  2  00 ALU, 01 MEM, 10 PC+8.
- `wb_rd`  out  5  destination register.
- `ex_muldiv_busy`  out  1  mult/div unit occupied.

## Operation

- Decode in ID, combinational:
  - `alu_b_imm` = I_ALU|Load|Store; `imm_ext_sign` = !ins[28]; `load_sign_ext` = !ins[28].
  - `overflow_aware` for add, sub and addi only.
  - ALU function map (R by funct, I by opcode): add/addu/addi/addiu/loads/stores→0; sub/subu→1; sllv→2; srlv→3; and/andi→4; or/ori→5; xor/xori→6; nor→7; slt/slti→8; sltu/sltiu→9; lui→E; otherwise F.
  - Destination: R-type→rd, I_ALU/Load→rt, jal→31, jalr→rd.
  - `gpr_we` = (R_ALU|I_ALU|Load|jal|jalr) & dest≠0. `gpr_src`: Load→01, jal/jalr→10, else 00.
- Source use: rs is read by R_ALU, I_ALU, Load, Store, Branch, jr/jalr. rt is read by R_ALU, Store, beq/bne.
- Load-use hazard: ex_valid & EX is load & ex_rd≠0 & ex_rd matches a used ID source. Response: `id_stall`=1, bubble into EX.
- Bubble: valid=0 and every write enable 0. Other fields don't care but are driven 0.
- Priority, highest first:
  1. `mem_stall`: all stage registers hold; `id_stall`=1.
  2. `ex_redirect`: the ID word is replaced by a bubble; `id_stall`=0 even if a hazard exists.
  3. Load-use or mult/div hazard.
  4. Normal advance.
- `id_valid`=0 enters EX as a bubble.

## Timing

- ID→EX, EX→MEM and MEM→WB are each one registered cycle; `id_stall` is combinational.
- Reset: all valids, enables, fields and `ex_muldiv_busy` are 0, and the counter is cleared. Reset mid-stall discards in-flight words.
- A load-use stall lasts exactly one cycle unless extended by `mem_stall`.

## Configuration

- `PIPE_CTL_MULDIV_EN` defined:
  - mult/multu/div/divu decode to ALU func A/B/C/D.
  - On entry to EX they load a counter with MULDIV_LAT; `ex_muldiv_busy`=1 while the counter is nonzero. The counter decrements even during `mem_stall`.
  - mfhi/mflo or a new mult/div in ID stalls while busy.
  - mfhi/mflo writes rd with `gpr_src` 00, ALU func F.
- Undefined: those functs decode as F with `gpr_we`=0, and `ex_muldiv_busy` is tied 0.

## Structure

- Shared package `pipe_ctl_pkg`:
  - ALU function constants.
  - `wb_gpr_src` and `pc_ctl_func` encodings.
  - Packed structs for the EX/MEM/WB control bundles.
- Combinational sub-module `ctl_decode` (instruction+flags → full control word); `pipe_ctl` holds the stage registers, hazard logic and counter.

## Test plan

- `lw $8,0($9)` then `add $10,$8,$11` → `id_stall`=1 for one cycle, ex_valid=0 next cycle, add reaches EX one cycle late.
- `lw $0,...` then a user of $0 → no stall.
- `jal` → after 3 cycles wb_gpr_we=1, wb_rd=31, wb_gpr_src=10.
- `ex_redirect` and load-use in the same cycle → `id_stall`=0, bubble into EX.
- `mem_stall` high 3 cycles during `sw` in MEM → all stage outputs constant, mem_we stays 1, `id_stall`=1.
- With `PIPE_CTL_MULDIV_EN`, MULDIV_LAT=4: `mult` then `mflo` → `ex_muldiv_busy` high 4 cycles, mflo held until it drops. `rst` mid-busy → busy=0 next cycle.

Source files
------------

// File: rtl/pipe_ctl_pkg.sv
// Encodings and control-bundle types shared by pipe_ctl and ctl_decode.
// Mult/div decode is enabled by the PIPE_CTL_MULDIV_EN macro in the files that import this package.
package pipe_ctl_pkg;

  localparam int ALU_W = 4;
  typedef logic [ALU_W-1:0] alu_func_t;

  localparam alu_func_t ALU_ADD   = 4'h0;
  localparam alu_func_t ALU_SUB   = 4'h1;
  localparam alu_func_t ALU_SLLV  = 4'h2;
  localparam alu_func_t ALU_SRLV  = 4'h3;
  localparam alu_func_t ALU_AND   = 4'h4;
  localparam alu_func_t ALU_OR    = 4'h5;
  localparam alu_func_t ALU_XOR   = 4'h6;
  localparam alu_func_t ALU_NOR   = 4'h7;
  localparam alu_func_t ALU_SLT   = 4'h8;
  localparam alu_func_t ALU_SLTU  = 4'h9;
  localparam alu_func_t ALU_MULT  = 4'hA;
  localparam alu_func_t ALU_MULTU = 4'hB;
  localparam alu_func_t ALU_DIV   = 4'hC;
  localparam alu_func_t ALU_DIVU  = 4'hD;
  localparam alu_func_t ALU_LUI   = 4'hE;
  localparam alu_func_t ALU_NOP   = 4'hF;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_JR     = 2'b11
  } pc_ctl_e;

  typedef enum logic [1:0] {
    SRC_ALU = 2'b00,
    SRC_MEM = 2'b01,
    SRC_PC8 = 2'b10
  } gpr_src_e;

  // Bit positions inside id_flags
  localparam int FL_R_ALU  = 7;
  localparam int FL_R_JR   = 6;
  localparam int FL_I_ALU  = 5;
  localparam int FL_BRANCH = 4;
  localparam int FL_LOAD   = 3;
  localparam int FL_STORE  = 2;
  localparam int FL_J      = 1;
  localparam int FL_ERET   = 0;

  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;

  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  typedef struct packed {
    logic      alu_b_imm;
    logic      imm_ext_sign;
    logic      overflow_aware;
    alu_func_t alu_func;
    pc_ctl_e   pc_ctl_func;
  } ex_ctl_t;

  typedef struct packed {
    logic       we;
    logic       re;
    logic       load_sign_ext;
    logic [1:0] data_len;
  } mem_ctl_t;

  typedef struct packed {
    logic       gpr_we;
    gpr_src_e   gpr_src;
    logic [4:0] rd;
  } wb_ctl_t;

  typedef struct packed {
    logic     valid;
    ex_ctl_t  ex;
    mem_ctl_t mem;
    wb_ctl_t  wb;
  } ex_word_t;

  typedef struct packed {
    logic     valid;
    mem_ctl_t mem;
    wb_ctl_t  wb;
  } mem_word_t;

  typedef struct packed {
    logic    valid;
    wb_ctl_t wb;
  } wb_word_t;

endpackage

// File: rtl/ctl_decode.sv
// Combinational decode of the ID instruction and classifier flags into a full control word.
// PIPE_CTL_MULDIV_EN enables mult/div/mfhi/mflo decode; otherwise they become non-writing NOPs.
module ctl_decode
  import pipe_ctl_pkg::*;
(
  input  logic [31:0] ins,
  input  logic [7:0]  flags,
  output ex_word_t    word,
  output logic        rs_used,
  output logic        rt_used,
  output logic        is_muldiv,
  output logic        is_hilo_rd
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       r_alu, r_jr, i_alu, branch, load, store, jump;
  logic       is_jal, is_jalr, no_gpr_write;
  logic [4:0] dest;
  alu_func_t  alu_func;
  logic       unused_fields;

  assign opcode = ins[31:26];
  assign funct  = ins[5:0];
  assign rt     = ins[20:16];
  assign rd     = ins[15:11];

  assign r_alu  = flags[FL_R_ALU];
  assign r_jr   = flags[FL_R_JR];
  assign i_alu  = flags[FL_I_ALU];
  assign branch = flags[FL_BRANCH];
  assign load   = flags[FL_LOAD];
  assign store  = flags[FL_STORE];
  assign jump   = flags[FL_J];

  assign unused_fields = ^{ins[10:6], flags[FL_ERET]};

  assign is_jal     = jump & (opcode == OP_JAL);
  assign is_jalr    = r_jr & (funct == FN_JALR);
  assign is_muldiv  = r_alu & (funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  assign is_hilo_rd = r_alu & (funct inside {FN_MFHI, FN_MFLO});

`ifdef PIPE_CTL_MULDIV_EN
  assign no_gpr_write = is_muldiv;
`else
  assign no_gpr_write = is_muldiv | is_hilo_rd;
`endif

  assign rs_used = r_alu | i_alu | load | store | branch | r_jr;
  assign rt_used = r_alu | store | (branch & ((opcode == OP_BEQ) | (opcode == OP_BNE)));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_func = ALU_NOP;
    if (load | store) begin
      alu_func = ALU_ADD;
    end else if (r_alu) begin
      case (funct)
        FN_ADD, FN_ADDU: alu_func = ALU_ADD;
        FN_SUB, FN_SUBU: alu_func = ALU_SUB;
        FN_SLLV:         alu_func = ALU_SLLV;
        FN_SRLV:         alu_func = ALU_SRLV;
        FN_AND:          alu_func = ALU_AND;
        FN_OR:           alu_func = ALU_OR;
        FN_XOR:          alu_func = ALU_XOR;
        FN_NOR:          alu_func = ALU_NOR;
        FN_SLT:          alu_func = ALU_SLT;
        FN_SLTU:         alu_func = ALU_SLTU;
`ifdef PIPE_CTL_MULDIV_EN
        FN_MULT:         alu_func = ALU_MULT;
        FN_MULTU:        alu_func = ALU_MULTU;
        FN_DIV:          alu_func = ALU_DIV;
        FN_DIVU:         alu_func = ALU_DIVU;
`endif
        default:         alu_func = ALU_NOP;
      endcase
    end else if (i_alu) begin
      case (opcode)
        OP_ADDI, OP_ADDIU: alu_func = ALU_ADD;
        OP_ANDI:           alu_func = ALU_AND;
        OP_ORI:            alu_func = ALU_OR;
        OP_XORI:           alu_func = ALU_XOR;
        OP_SLTI:           alu_func = ALU_SLT;
        OP_SLTIU:          alu_func = ALU_SLTU;
        OP_LUI:            alu_func = ALU_LUI;
        default:           alu_func = ALU_NOP;
      endcase
    end
  end

  always_comb begin
    dest = 5'd0;
    if (r_alu | is_jalr) dest = rd;
    else if (i_alu | load) dest = rt;
    else if (is_jal) dest = 5'd31;
  end

  always_comb begin
    word = '0;
    word.valid = 1'b1;

    word.ex.alu_b_imm      = i_alu | load | store;
    word.ex.imm_ext_sign   = ~ins[28];
    word.ex.overflow_aware = (r_alu & ((funct == FN_ADD) | (funct == FN_SUB)))
                           | (i_alu & (opcode == OP_ADDI));
    word.ex.alu_func       = alu_func;
    if (r_jr)        word.ex.pc_ctl_func = PC_JR;
    else if (jump)   word.ex.pc_ctl_func = PC_JUMP;
    else if (branch) word.ex.pc_ctl_func = PC_BRANCH;
    else             word.ex.pc_ctl_func = PC_SEQ;

    word.mem.we            = store;
    word.mem.re            = load;
    word.mem.load_sign_ext = ~ins[28];
    word.mem.data_len      = ins[27:26];

    word.wb.rd     = dest;
    word.wb.gpr_we = (r_alu | i_alu | load | is_jal | is_jalr) & (dest != 5'd0) & ~no_gpr_write;
    if (load)                  word.wb.gpr_src = SRC_MEM;
    else if (is_jal | is_jalr) word.wb.gpr_src = SRC_PC8;
    else                       word.wb.gpr_src = SRC_ALU;
  end

endmodule

// File: rtl/pipe_ctl.sv
// Pipelined control unit: ID decode, EX/MEM/WB control registers, load-use and mult/div interlocks.
// Define PIPE_CTL_MULDIV_EN to enable the mult/div occupancy counter and its hazard.
module pipe_ctl
  import pipe_ctl_pkg::*;
#(
  parameter int ALU_FUNC_W = 4,
  parameter int MULDIV_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           id_ins,
  input  logic [7:0]            id_flags,
  input  logic                  id_valid,
  input  logic                  mem_stall,
  input  logic                  ex_redirect,
  output logic                  id_stall,
  output logic                  ex_valid,
  output logic                  ex_alu_b_imm,
  output logic                  ex_imm_ext_sign,
  output logic                  ex_overflow_aware,
  output logic [ALU_FUNC_W-1:0] ex_alu_func,
  output logic [1:0]            ex_pc_ctl_func,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic                  mem_load_sign_ext,
  output logic [1:0]            mem_data_len,
  output logic                  wb_valid,
  output logic                  wb_gpr_we,
  output logic [1:0]            wb_gpr_src,
  output logic [4:0]            wb_rd,
  output logic                  ex_muldiv_busy
);

  ex_word_t  id_word, ex_d, ex_q;
  mem_word_t mem_q;
  wb_word_t  wb_q;
  logic      rs_used, rt_used, is_muldiv, is_hilo_rd;
  logic      load_use, muldiv_hazard, hazard, insert_bubble;
  logic [4:0] id_rs, id_rt;

  ctl_decode u_decode (
    .ins        (id_ins),
    .flags      (id_flags),
    .word       (id_word),
    .rs_used    (rs_used),
    .rt_used    (rt_used),
    .is_muldiv  (is_muldiv),
    .is_hilo_rd (is_hilo_rd)
  );

  assign id_rs = id_ins[25:21];
  assign id_rt = id_ins[20:16];

  assign load_use = id_valid & ex_q.valid & ex_q.mem.re & (ex_q.wb.rd != 5'd0)
                  & ((rs_used & (id_rs == ex_q.wb.rd)) | (rt_used & (id_rt == ex_q.wb.rd)));

  assign hazard        = load_use | muldiv_hazard;
  // A redirect kills the ID word, so a hazard against it no longer needs a hold.
  assign insert_bubble = ex_redirect | hazard | ~id_valid;
  assign ex_d          = insert_bubble ? '0 : id_word;
  assign id_stall      = mem_stall | (hazard & ~ex_redirect);

  // NOTE: non-blocking assignments so each stage captures its upstream's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!mem_stall) begin
      ex_q  <= ex_d;
      mem_q <= '{valid: ex_q.valid, mem: ex_q.mem, wb: ex_q.wb};
      wb_q  <= '{valid: mem_q.valid, wb: mem_q.wb};
    end
  end

`ifdef PIPE_CTL_MULDIV_EN
  logic [3:0] md_cnt;
  logic       md_busy;

  assign md_busy        = (md_cnt != 4'd0);
  assign muldiv_hazard  = id_valid & (is_muldiv | is_hilo_rd) & md_busy;
  assign ex_muldiv_busy = md_busy;

  // The unit keeps computing while memory stalls, so the count runs regardless of mem_stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt <= 4'd0;
    end else if (!mem_stall && !insert_bubble && is_muldiv) begin
      md_cnt <= 4'(MULDIV_LAT);
    end else if (md_busy) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end
`else
  logic unused_muldiv;

  assign muldiv_hazard  = 1'b0;
  assign ex_muldiv_busy = 1'b0;
  assign unused_muldiv  = is_muldiv ^ is_hilo_rd ^ (MULDIV_LAT > 0);
`endif

  assign ex_valid          = ex_q.valid;
  assign ex_alu_b_imm      = ex_q.ex.alu_b_imm;
  assign ex_imm_ext_sign   = ex_q.ex.imm_ext_sign;
  assign ex_overflow_aware = ex_q.ex.overflow_aware;
  assign ex_alu_func       = ALU_FUNC_W'(ex_q.ex.alu_func);
  assign ex_pc_ctl_func    = ex_q.ex.pc_ctl_func;

  assign mem_valid         = mem_q.valid;
  assign mem_we            = mem_q.mem.we;
  assign mem_re            = mem_q.mem.re;
  assign mem_load_sign_ext = mem_q.mem.load_sign_ext;
  assign mem_data_len      = mem_q.mem.data_len;

  assign wb_valid          = wb_q.valid;
  assign wb_gpr_we         = wb_q.wb.gpr_we;
  assign wb_gpr_src        = wb_q.wb.gpr_src;
  assign wb_rd             = wb_q.wb.rd;

endmodule

// File: tb/tb_pipe_ctl.sv
// Self-checking bench for pipe_ctl: a decode vector table plus hand-built hazard/stall sequences.
// Mult/div expectations follow PIPE_CTL_MULDIV_EN, matching the RTL build.
module tb_pipe_ctl;

  logic        clk = 1'b0;
  logic        rst, id_valid, mem_stall, ex_redirect;
  logic [31:0] id_ins;
  logic [7:0]  id_flags;
  logic        id_stall, ex_valid, ex_alu_b_imm, ex_imm_ext_sign, ex_overflow_aware;
  logic [3:0]  ex_alu_func;
  logic [1:0]  ex_pc_ctl_func;
  logic        mem_valid, mem_we, mem_re, mem_load_sign_ext;
  logic [1:0]  mem_data_len;
  logic        wb_valid, wb_gpr_we;
  logic [1:0]  wb_gpr_src;
  logic [4:0]  wb_rd;
  logic        ex_muldiv_busy;

  always #5 clk = ~clk;

  pipe_ctl #(.ALU_FUNC_W(4), .MULDIV_LAT(4)) dut (
    .clk(clk), .rst(rst), .id_ins(id_ins), .id_flags(id_flags), .id_valid(id_valid),
    .mem_stall(mem_stall), .ex_redirect(ex_redirect), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_alu_b_imm(ex_alu_b_imm), .ex_imm_ext_sign(ex_imm_ext_sign),
    .ex_overflow_aware(ex_overflow_aware), .ex_alu_func(ex_alu_func),
    .ex_pc_ctl_func(ex_pc_ctl_func), .mem_valid(mem_valid), .mem_we(mem_we), .mem_re(mem_re),
    .mem_load_sign_ext(mem_load_sign_ext), .mem_data_len(mem_data_len), .wb_valid(wb_valid),
    .wb_gpr_we(wb_gpr_we), .wb_gpr_src(wb_gpr_src), .wb_rd(wb_rd),
    .ex_muldiv_busy(ex_muldiv_busy)
  );

  localparam logic [7:0] F_RALU = 8'h80, F_RJR = 8'h40, F_IALU = 8'h20, F_BR = 8'h10;
  localparam logic [7:0] F_LD = 8'h08, F_ST = 8'h04, F_J = 8'h02;

`ifdef PIPE_CTL_MULDIV_EN
  localparam logic [3:0] MULT_FUNC = 4'hA;
  localparam logic       MFLO_WE   = 1'b1;
`else
  localparam logic [3:0] MULT_FUNC = 4'hF;
  localparam logic       MFLO_WE   = 1'b0;
`endif

  // ex: {alu_b_imm, imm_ext_sign, overflow_aware, alu_func, pc_ctl_func}
  // mem: {we, re, load_sign_ext, data_len}   wb: {gpr_we, gpr_src, rd}
  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [7:0]  flags;
    logic [8:0]  ex_exp;
    logic [4:0]  mem_exp;
    logic [7:0]  wb_exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [7:0] fl, input logic v);
    id_ins   = ins;
    id_flags = fl;
    id_valid = v;
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic add_vec(input string n, input logic [31:0] ins, input logic [7:0] fl,
                         input logic [8:0] e, input logic [4:0] m, input logic [7:0] w);
    vec_t v;
    v.name = n; v.ins = ins; v.flags = fl; v.ex_exp = e; v.mem_exp = m; v.wb_exp = w;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; mem_stall = 1'b0; ex_redirect = 1'b0;
    drive(32'd0, 8'd0, 1'b0);

    add_vec("add",   r_ins(8, 11, 10, 6'h20),      F_RALU, 9'b0_1_1_0000_00, 5'b0_0_1_00, 8'b1_00_01010);
    add_vec("sub",   r_ins(4, 5, 3, 6'h22),        F_RALU, 9'b0_1_1_0001_00, 5'b0_0_1_00, 8'b1_00_00011);
    add_vec("nor0",  r_ins(1, 2, 0, 6'h27),        F_RALU, 9'b0_1_0_0111_00, 5'b0_0_1_00, 8'b0_00_00000);
    add_vec("sltu",  r_ins(1, 2, 7, 6'h2b),        F_RALU, 9'b0_1_0_1001_00, 5'b0_0_1_00, 8'b1_00_00111);
    add_vec("srlv",  r_ins(1, 2, 6, 6'h06),        F_RALU, 9'b0_1_0_0011_00, 5'b0_0_1_00, 8'b1_00_00110);
    add_vec("addi",  i_ins(6'h08, 1, 9, 16'd5),    F_IALU, 9'b1_1_1_0000_00, 5'b0_0_1_00, 8'b1_00_01001);
    add_vec("ori",   i_ins(6'h0d, 1, 12, 16'hff),  F_IALU, 9'b1_0_0_0101_00, 5'b0_0_0_01, 8'b1_00_01100);
    add_vec("slti",  i_ins(6'h0a, 1, 2, 16'd3),    F_IALU, 9'b1_1_0_1000_00, 5'b0_0_1_10, 8'b1_00_00010);
    add_vec("lui",   i_ins(6'h0f, 0, 13, 16'h1234),F_IALU, 9'b1_0_0_1110_00, 5'b0_0_0_11, 8'b1_00_01101);
    add_vec("lb",    i_ins(6'h20, 2, 14, 16'd0),   F_LD,   9'b1_1_0_0000_00, 5'b0_1_1_00, 8'b1_01_01110);
    add_vec("lhu",   i_ins(6'h25, 2, 15, 16'd2),   F_LD,   9'b1_0_0_0000_00, 5'b0_1_0_01, 8'b1_01_01111);
    add_vec("sw",    i_ins(6'h2b, 6, 5, 16'd4),    F_ST,   9'b1_1_0_0000_00, 5'b1_0_1_11, 8'b0_00_00000);
    add_vec("beq",   i_ins(6'h04, 1, 2, 16'd8),    F_BR,   9'b0_0_0_1111_01, 5'b0_0_0_00, 8'b0_00_00000);
    add_vec("j",     {6'h02, 26'h40},              F_J,    9'b0_1_0_1111_10, 5'b0_0_1_10, 8'b0_00_00000);
    add_vec("jal",   {6'h03, 26'h80},              F_J,    9'b0_1_0_1111_10, 5'b0_0_1_11, 8'b1_10_11111);
    add_vec("jr",    r_ins(31, 0, 0, 6'h08),       F_RJR,  9'b0_1_0_1111_11, 5'b0_0_1_00, 8'b0_00_00000);
    add_vec("jalr",  r_ins(5, 0, 4, 6'h09),        F_RJR,  9'b0_1_0_1111_11, 5'b0_0_1_00, 8'b1_10_00100);
    add_vec("mflo",  r_ins(0, 0, 4, 6'h12),        F_RALU, 9'b0_1_0_1111_00, 5'b0_0_1_00, {MFLO_WE, 7'b00_00100});
    add_vec("mult",  r_ins(1, 2, 0, 6'h18),        F_RALU, {3'b010, MULT_FUNC, 2'b00}, 5'b0_0_1_00, 8'b0_00_00000);

    // Reset state
    tick();
    tick();
    check("reset.valids", {ex_valid, mem_valid, wb_valid}, 3'b000);
    check("reset.enables", {mem_we, mem_re, wb_gpr_we, ex_muldiv_busy, id_stall}, 5'b00000);
    check("reset.fields", {ex_alu_func, ex_pc_ctl_func, wb_rd, wb_gpr_src}, 13'd0);
    rst = 1'b0;

    // Decode table: each vector is followed by idle slots and checked in EX, MEM and WB
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ins, vecs[i].flags, 1'b1);
      #1 check({vecs[i].name, ".stall"}, id_stall, 1'b0);
      tick();
      check({vecs[i].name, ".ex"},
            {ex_valid, ex_alu_b_imm, ex_imm_ext_sign, ex_overflow_aware, ex_alu_func, ex_pc_ctl_func},
            {1'b1, vecs[i].ex_exp});
      drive(32'd0, 8'd0, 1'b0);
      tick();
      check({vecs[i].name, ".mem"},
            {mem_valid, mem_we, mem_re, mem_load_sign_ext, mem_data_len}, {1'b1, vecs[i].mem_exp});
      tick();
      check({vecs[i].name, ".wb"}, {wb_valid, wb_gpr_we, wb_gpr_src, wb_rd}, {1'b1, vecs[i].wb_exp});
    end
    for (int i = 0; i < 4; i++) tick();

    // Load-use: lw $8 then add $10,$8,$11
    drive(i_ins(6'h23, 9, 8, 16'd0), F_LD, 1'b1);
    tick();
    drive(r_ins(8, 11, 10, 6'h20), F_RALU, 1'b1);
    #1 check("lu.stall", id_stall, 1'b1);
    tick();
    check("lu.bubble", ex_valid, 1'b0);
    check("lu.lw_mem", {mem_valid, mem_re}, 2'b11);
    check("lu.release", id_stall, 1'b0);
    tick();
    check("lu.add_ex", {ex_valid, ex_overflow_aware, ex_alu_func}, {1'b1, 1'b1, 4'h0});
    drive(32'd0, 8'd0, 1'b0);
    tick();

    // Load into $0 never creates a hazard
    drive(i_ins(6'h23, 9, 0, 16'd0), F_LD, 1'b1);
    tick();
    drive(r_ins(0, 11, 10, 6'h20), F_RALU, 1'b1);
    #1 check("lw0.stall", id_stall, 1'b0);
    tick();
    check("lw0.ex", ex_valid, 1'b1);
    drive(32'd0, 8'd0, 1'b0);
    tick();

    // Redirect wins over load-use
    drive(i_ins(6'h23, 9, 8, 16'd0), F_LD, 1'b1);
    tick();
    drive(r_ins(8, 11, 10, 6'h20), F_RALU, 1'b1);
    ex_redirect = 1'b1;
    #1 check("redir.stall", id_stall, 1'b0);
    tick();
    check("redir.bubble", {ex_valid, ex_alu_func, ex_overflow_aware}, 6'd0);
    ex_redirect = 1'b0;
    drive(32'd0, 8'd0, 1'b0);
    tick();

    // mem_stall for 3 cycles with sw in MEM and add in EX
    drive(i_ins(6'h2b, 6, 5, 16'd4), F_ST, 1'b1);
    tick();
    drive(r_ins(1, 2, 10, 6'h20), F_RALU, 1'b1);
    tick();
    drive(i_ins(6'h0d, 1, 12, 16'hff), F_IALU, 1'b1);
    mem_stall = 1'b1;
    #1 check("ms.stall0", id_stall, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ms.mem", {mem_valid, mem_we, mem_data_len}, 4'b1111);
      check("ms.ex", {ex_valid, ex_alu_func, ex_overflow_aware}, {1'b1, 4'h0, 1'b1});
      check("ms.wb", wb_valid, 1'b0);
      check("ms.stall", id_stall, 1'b1);
    end
    mem_stall = 1'b0;
    tick();
    check("ms.after_wb", {wb_valid, wb_gpr_we}, 2'b10);
    check("ms.after_mem", {mem_valid, mem_we}, 2'b10);
    check("ms.after_ex", {ex_valid, ex_alu_func}, {1'b1, 4'h5});
    drive(32'd0, 8'd0, 1'b0);
    tick();
    tick();

    // Reset in the middle of a load-use stall
    drive(i_ins(6'h23, 9, 8, 16'd0), F_LD, 1'b1);
    tick();
    drive(r_ins(8, 11, 10, 6'h20), F_RALU, 1'b1);
    #1 check("rst.pre_stall", id_stall, 1'b1);
    rst = 1'b1;
    tick();
    check("rst.flush", {ex_valid, mem_valid, wb_valid, id_stall}, 4'b0000);
    rst = 1'b0;
    drive(32'd0, 8'd0, 1'b0);
    tick();

    // id_valid=0 enters EX as an all-zero bubble
    drive(i_ins(6'h0f, 0, 13, 16'h1234), F_IALU, 1'b0);
    tick();
    check("inval.bubble", {ex_valid, ex_alu_b_imm, ex_alu_func}, 6'd0);
    drive(32'd0, 8'd0, 1'b0);
    tick();

`ifdef PIPE_CTL_MULDIV_EN
    // mult then mflo: busy for MULDIV_LAT cycles, mflo held until it drops
    drive(r_ins(1, 2, 0, 6'h18), F_RALU, 1'b1);
    tick();
    drive(r_ins(0, 0, 4, 6'h12), F_RALU, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("md.busy", ex_muldiv_busy, 1'b1);
      check("md.hold", id_stall, 1'b1);
      tick();
    end
    check("md.idle", {ex_muldiv_busy, id_stall, ex_valid}, 3'b000);
    tick();
    check("md.mflo_ex", {ex_valid, ex_alu_func}, {1'b1, 4'hF});
    drive(r_ins(1, 2, 0, 6'h18), F_RALU, 1'b1);
    tick();
    drive(32'd0, 8'd0, 1'b0);
    tick();
    check("md.busy_pre_rst", ex_muldiv_busy, 1'b1);
    rst = 1'b1;
    tick();
    check("md.rst", ex_muldiv_busy, 1'b0);
    rst = 1'b0;
`else
    // Without the unit, mult never makes anything busy and mflo is not held
    drive(r_ins(1, 2, 0, 6'h18), F_RALU, 1'b1);
    tick();
    drive(r_ins(0, 0, 4, 6'h12), F_RALU, 1'b1);
    #1 check("nomd.stall", {ex_muldiv_busy, id_stall}, 2'b00);
    tick();
    check("nomd.mflo_ex", {ex_valid, ex_alu_func}, {1'b1, 4'hF});
    drive(32'd0, 8'd0, 1'b0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
